// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter: round-robin arbiter sharing the
// single-ported register file between two masters.
module rf_access_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_wr,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_rvalid,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_wr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_rvalid,
  output logic                  m1_err,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  input  logic                  rf_rd_valid,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RD_WAIT
  } state_t;

  // last RD_WAIT count before the read is declared lost
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                  state;
  logic                    ptr;
  logic                    owner;
  logic                    op_wr;
  logic [7:0]              cnt;
  logic                    win;
  logic                    win_wr;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic [DATA_WIDTH-1:0]   win_wdata;

  // winner: pointer port on contention, else sole requester
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (m0_req && m1_req):  win = ptr;
      (m1_req && !m0_req): win = 1'b1;
      default:             win = 1'b0;
    endcase
    win_wr    = win ? m1_wr    : m0_wr;
    win_addr  = win ? m1_addr  : m0_addr;
    win_wdata = win ? m1_wdata : m0_wdata;
  end

  // arbitration FSM with registered strobes and responses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      owner      <= 1'b0;
      op_wr      <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      rf_addr    <= '0;
      rf_wr_data <= '0;
    end else begin
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      rf_wr_en  <= 1'b0;
      rf_rd_en  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            state      <= ISSUE;
            busy       <= 1'b1;
            owner      <= win;
            op_wr      <= win_wr;
            ptr        <= ~win;
            m0_gnt     <= ~win;
            m1_gnt     <= win;
            rf_addr    <= win_addr;
            rf_wr_en   <= win_wr;
            rf_rd_en   <= ~win_wr;
            rf_wr_data <= win_wr ? win_wdata : '0;
          end
        end
        ISSUE: begin
          cnt <= '0;
          if (op_wr) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rf_rd_valid) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (owner) begin
              m1_rdata  <= rf_rd_data;
              m1_rvalid <= 1'b1;
            end else begin
              m0_rdata  <= rf_rd_data;
              m0_rvalid <= 1'b1;
            end
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (owner) begin
              m1_rdata <= '0;
              m1_err   <= 1'b1;
            end else begin
              m0_rdata <= '0;
              m0_err   <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rf_access_arbiter.md
# rf_access_arbiter

Two-port arbiter that shares the single-ported register file between the UART command controller (port 0) and a second register-file master (port 1). It serialises single-beat read/write requests with round-robin fairness, drives the register file's `wr_en`/`rd_en`/`addres`/`wr_data` strobes, and returns read data or a timeout error to the owning requester. It sits between the requesters and the register file in the reference clock domain.

## Interface
- `DATA_WIDTH`, 8: register data width.
- `ADDR_WIDTH`, 4: register address width.
- `TIMEOUT`, 15: max RD_WAIT cycles before error; legal range 1..255.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `mN_req` in 1 (N=0,1): request; held with `mN_wr`/`mN_addr`/`mN_wdata` stable until `mN_gnt`.
- `mN_wr` in 1: 1 = write, 0 = read.
- `mN_addr` in ADDR_WIDTH: register address.
- `mN_wdata` in DATA_WIDTH: write data.
- `mN_gnt` out 1: one-cycle pulse; request accepted.
- `mN_rdata` out DATA_WIDTH: read data; holds until next `mN_rvalid`/`mN_err`.
- `mN_rvalid` out 1: one-cycle pulse; `mN_rdata` valid.
- `mN_err` out 1: one-cycle pulse; read timed out, `mN_rdata` = 0.
- `rf_wr_en` out 1: register-file write strobe.
- `rf_rd_en` out 1: register-file read strobe.
- `rf_addr` out ADDR_WIDTH: register-file address.
- `rf_wr_data` out DATA_WIDTH: register-file write data.
- `rf_rd_data` in DATA_WIDTH: register-file read data.
- `rf_rd_valid` in 1: read data valid.
- `busy` out 1: high whenever state != IDLE.

## Operation
- All outputs registered. Reset: state IDLE, priority pointer = port 0, timeout counter 0, every output 0.
- States: IDLE, ISSUE, RD_WAIT.
- IDLE: if any `mN_req`, select the winner (both requesting: pointer port wins; else the sole requester), latch owner/op/addr/wdata, go to ISSUE; pointer <= other port.
- ISSUE (exactly 1 cycle): `mN_gnt`=1 for the owner; `rf_addr` = latched addr; write: `rf_wr_en`=1, `rf_wr_data` = latched data, next IDLE; read: `rf_rd_en`=1, `rf_wr_data`=0, counter cleared, next RD_WAIT.
- RD_WAIT: `rf_addr` held, strobes 0. If `rf_rd_valid`: owner `mN_rdata` <= `rf_rd_data`, `mN_rvalid`=1 next cycle, next IDLE. Else counter++. When counter reaches TIMEOUT with no valid: `mN_rdata` <= 0, `mN_err`=1 next cycle, next IDLE.
- Same-cycle `rf_rd_valid` and timeout: valid wins.
- `rf_rd_valid` outside RD_WAIT: ignored.
- Non-owner outputs unchanged throughout.
- Reset mid-transaction: transaction dropped, no gnt/rvalid/err, pointer back to port 0.

## Timing
- Request sampled in cycle N (IDLE) -> `gnt` plus `rf_*_en` in N+1.
- Write: IDLE again in N+2; max write rate one per 2 cycles.
- Read with a 1-cycle register file (`rf_rd_valid` in N+2): `rvalid` in N+3, IDLE in N+3. New request arbitration is possible in the same cycle as `rvalid`.
- Timeout: `err` asserted TIMEOUT+1 cycles after ISSUE.
- Requester drops `req` the cycle after seeing `gnt`. A still-high `req` in IDLE is a new request.
- `busy` = 1 from N+1 until the return to IDLE.

## Test plan
- Reset -> all outputs 0, `busy`=0. Port 0 writes 0x5A to addr 3 -> `m0_gnt`, `rf_wr_en`, `rf_addr`=3, `rf_wr_data`=0x5A in the same cycle, 2-cycle turnaround.
- Port 1 reads addr 7; register file returns 0xC3 one cycle after `rf_rd_en` -> `m1_rvalid` with `m1_rdata`=0xC3 at N+3; `m0_rvalid` stays 0.
- Both ports continuously requesting writes after reset -> grants alternate 0,1,0,1, one every 2 cycles.
- Port 0 reads and `rf_rd_valid` never arrives (TIMEOUT=15) -> `m0_err` pulse 16 cycles after ISSUE, `m0_rdata`=0, IDLE. `rf_rd_valid` exactly at the timeout cycle -> `rvalid`, no `err`.
- Reset asserted in RD_WAIT, then late `rf_rd_valid` after release -> no `rvalid`/`err`; next simultaneous request -> port 0 wins.
- Spurious `rf_rd_valid` in IDLE/ISSUE -> no `rvalid`, `mN_rdata` unchanged.
